div_unit: RTL and testbench

Multi-cycle 32-bit integer divider serving the `div`/`divu` instructions of the five-stage core. It is instantiated beside the EX stage. EX holds the pipeline, pulses a start request with both operands, and consumes the 64-bit {remainder, quotient} result. That result travels down EX/MEM → MEM → MEM/WB to `hilo_reg` as HI = remainder, LO = quotient. The divider uses one restoring quotient bit per clock and supports signed and unsigned division, divide-by-zero, and annulment when EX flushes the instruction.

---
 rtl/div_unit_if.sv | 40 ++++
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
//   signed_div_i : 1 = signed (div), 0 = unsigned (divu), sampled with start_i
//   opdata1_i    : dividend, sampled with start_i
//   opdata2_i    : divisor, sampled with start_i
//   start_i      : request, held high by EX until the result is taken
//   annul_i      : abort the division in progress
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result valid, registered
// master = EX stage side, slave = divider side.
interface div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider for div/divu, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : div_unit_if slave modport (operands, start/annul, result, ready)
// Result format is {remainder, quotient}; the remainder follows the dividend's
// sign and the quotient is negated when operand signs differ (signed mode only).
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    div_unit_if.slave     bus
);

    localparam int unsigned         CntW    = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0]     CntLast = CntW'(DATA_W);
    localparam logic [DATA_W-1:0]   OneW    = DATA_W'(1);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    // {partial remainder (DATA_W+1 bits), dividend bits shifting out / quotient shifting in}
    logic [2*DATA_W:0]      work_q, work_d;
    logic [DATA_W-1:0]      divisor_q, divisor_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]    result_q, result_d;
    logic                   ready_q, ready_d;

    // Operand magnitudes at the start edge
    logic                   a_neg, b_neg;
    logic [DATA_W-1:0]      a_mag, b_mag;

    // One iteration: shift in next dividend bit, trial-subtract the divisor.
    // One extra bit above the DATA_W+1 remainder holds the borrow.
    logic [DATA_W:0]        shifted_rem;
    logic [DATA_W+1:0]      trial;

    // Final sign correction
    logic [DATA_W-1:0]      quo_mag, rem_mag, quo_fix, rem_fix;

    always_comb begin
        a_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        b_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        a_mag = a_neg ? (~bus.opdata1_i + OneW) : bus.opdata1_i;
        b_mag = b_neg ? (~bus.opdata2_i + OneW) : bus.opdata2_i;

        shifted_rem = work_q[2*DATA_W-1:DATA_W-1];
        trial       = {1'b0, shifted_rem} - {2'b00, divisor_q};

        quo_mag = work_q[DATA_W-1:0];
        rem_mag = work_q[2*DATA_W-1:DATA_W];
        quo_fix = neg_quo_q ? (~quo_mag + OneW) : quo_mag;
        rem_fix = neg_rem_q ? (~rem_mag + OneW) : rem_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            StFree: begin
                result_d = '0;
                ready_d  = 1'b0;
                // annul_i blocks a start presented in the same cycle
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = StByZero;
                    end else begin
                        work_d    = {{(DATA_W+1){1'b0}}, a_mag};
                        divisor_d = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        state_d   = StOn;
                    end
                end
            end
            StByZero: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = StEnd;
            end
            StOn: begin
                // Annul wins even on the completion edge
                if (bus.annul_i) begin
                    cnt_d   = '0;
                    state_d = StFree;
                end else if (cnt_q == CntLast) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                end else begin
                    if (!trial[DATA_W+1]) begin
                        work_d = {trial[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
                    end else begin
                        work_d = {shifted_rem, work_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEnd: begin
                if (!bus.start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = StFree;
                end
            end
            default: begin
                state_d = StFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and take the start edge (E0); returns #1 after E0.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Count edges after the start edge until ready_o is seen, bounded at 40.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (!bus.ready_o && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic drop_start();
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_total++;
        if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.ready_o);
        else n_pass++;
        n_total++;
        if (bus.result_o !== 64'h0) $display("FAIL reset_result got=%h exp=0", bus.result_o);
        else n_pass++;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        int e;
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(e);
        n_total++;
        if (e !== 33) $display("FAIL u100_7_latency got=%0d exp=33", e);
        else n_pass++;
        n_total++;
        if (bus.result_o !== {32'h2, 32'hE}) $display("FAIL u100_7_result got=%h exp=%h", bus.result_o, {32'h2, 32'hE});
        else n_pass++;
        drop_start();
        n_total++;
        if (bus.ready_o !== 1'b0) $display("FAIL u100_7_drop_ready got=%b exp=0", bus.ready_o);
        else n_pass++;
        n_total++;
        if (bus.result_o !== 64'h0) $display("FAIL u100_7_drop_result got=%h exp=0", bus.result_o);
        else n_pass++;
    endtask

    task automatic test_signed();
        int e;
        launch(1'b1, 32'hFFFF_FFF9, 32'h2);
        wait_ready(e);
        n_total++;
        if (bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL s_m7_2 got=%h exp=%h", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        else n_pass++;
        drop_start();
        launch(1'b0, 32'hFFFF_FFF9, 32'h2);
        wait_ready(e);
        n_total++;
        if (bus.result_o !== {32'h1, 32'h7FFF_FFFC})
            $display("FAIL u_fff9_2 got=%h exp=%h", bus.result_o, {32'h1, 32'h7FFF_FFFC});
        else n_pass++;
        drop_start();
    endtask

    task automatic test_div_zero();
        int e;
        launch(1'b0, 32'd5, 32'd0);
        wait_ready(e);
        n_total++;
        if (e !== 1) $display("FAIL div0_latency got=%0d exp=1", e);
        else n_pass++;
        n_total++;
        if (bus.result_o !== 64'h0) $display("FAIL div0_result got=%h exp=0", bus.result_o);
        else n_pass++;
        // annul_i in END is ignored
        bus.annul_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h0)
                $display("FAIL div0_hold%0d got ready=%b result=%h exp ready=1 result=0", i, bus.ready_o, bus.result_o);
            else n_pass++;
        end
        bus.annul_i = 1'b0;
        drop_start();
        n_total++;
        if (bus.ready_o !== 1'b0) $display("FAIL div0_drop_ready got=%b exp=0", bus.ready_o);
        else n_pass++;
    endtask

    task automatic test_annul();
        int   e;
        logic seen;
        launch(1'b0, 32'd20, 32'd4);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        // cnt is 10 here; annul on the next edge, then keep start+annul high
        bus.annul_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL annul_ready got=%b exp=0", seen);
        else n_pass++;
        bus.annul_i = 1'b0;
        @(posedge clk);
        #1;
        wait_ready(e);
        n_total++;
        if (e !== 33) $display("FAIL annul_restart_latency got=%0d exp=33", e);
        else n_pass++;
        n_total++;
        if (bus.result_o !== {32'h0, 32'h5}) $display("FAIL annul_restart_result got=%h exp=%h", bus.result_o, {32'h0, 32'h5});
        else n_pass++;
        drop_start();
    endtask

    task automatic test_reset_mid();
        int e;
        launch(1'b0, 32'd100, 32'd7);
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
            $display("FAIL reset_mid got ready=%b result=%h exp ready=0 result=0", bus.ready_o, bus.result_o);
        else n_pass++;
        bus.start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(e);
        n_total++;
        if (e !== 33) $display("FAIL ovf_latency got=%0d exp=33", e);
        else n_pass++;
        n_total++;
        if (bus.result_o !== {32'h0, 32'h8000_0000}) $display("FAIL ovf_result got=%h exp=%h", bus.result_o, {32'h0, 32'h8000_0000});
        else n_pass++;
        drop_start();
    endtask

    task automatic test_reset_in_end();
        int e;
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(e);
        n_total++;
        if (bus.result_o !== {32'h2, 32'hE}) $display("FAIL end_pre_reset got=%h exp=%h", bus.result_o, {32'h2, 32'hE});
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
            $display("FAIL reset_in_end got ready=%b result=%h exp ready=0 result=0", bus.ready_o, bus.result_o);
        else n_pass++;
        bus.start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_operand_stability();
        int e;
        launch(1'b0, 32'hFFFF_FFFF, 32'h1);
        bus.opdata1_i    = 32'h1234_5678;
        bus.opdata2_i    = 32'h3;
        bus.signed_div_i = 1'b1;
        wait_ready(e);
        n_total++;
        if (bus.result_o !== {32'h0, 32'hFFFF_FFFF}) $display("FAIL stable_result got=%h exp=%h", bus.result_o, {32'h0, 32'hFFFF_FFFF});
        else n_pass++;
        drop_start();
    endtask

    task automatic test_back_to_back();
        int e;
        // Launch right after the previous handshake returned to FREE
        launch(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_ready(e);
        n_total++;
        if (bus.result_o !== {32'h2, 32'hFFFF_FFF2}) $display("FAIL b2b_result got=%h exp=%h", bus.result_o, {32'h2, 32'hFFFF_FFF2});
        else n_pass++;
        drop_start();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_reset_in_end();
        test_operand_stability();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
